// File: rtl/pooling_stream_controller_pkg.sv
// Shared definitions for layer sequencers: state encoding and the size
// helpers used to dimension frame counters.
package pooling_stream_controller_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DRAIN  = 2'd3
  } seq_state_t;

  // Bits needed to hold the values 0..n-1 (at least one bit).
  function automatic int log2_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  // Output side length of a pooling window sweep.
  function automatic int pool_out_dim(input int img, input int filt, input int stride);
    return (img - filt) / stride + 1;
  endfunction

endpackage

// File: rtl/pooling_stream_controller_output_reg.sv
// Single-entry output register: holds one pooled result plus its last flag
// until the downstream stage takes it.
module stream_output_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  output logic             m_last
);

  // NOTE: non-blocking assignments make every register here sample pre-edge
  // values, so statement order inside the block cannot change behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data register is reset as well, so m_data reads zero after
      // reset instead of exposing a stale pixel from an aborted frame.
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else if (load) begin
      // A load wins over an accept: the old beat leaves as the new one lands.
      m_data  <= load_data;
      m_valid <= 1'b1;
      m_last  <= load_last;
    end else if (m_ready) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/pooling_stream_controller.sv
// Frame sequencer for one pooling layer: meters pixels into the layer,
// flushes it after the last pixel and registers the pooled outputs.
module pooling_stream_controller
  import pooling_stream_controller_pkg::*;
#(
  parameter int D_WIDTH     = 8,
  parameter int CHANNELS    = 1,
  parameter int IMAGE_SIZE  = 28,
  parameter int FILTER_SIZE = 2,
  parameter int STRIDE      = 2,
  parameter int FLUSH_MAX   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         frame_err,
  input  logic [D_WIDTH*CHANNELS-1:0]  s_data,
  input  logic                         s_valid,
  input  logic                         s_last,
  output logic                         s_ready,
  output logic                         pool_clk_en,
  output logic [D_WIDTH*CHANNELS-1:0]  pool_in,
  input  logic [D_WIDTH*CHANNELS-1:0]  pool_data,
  input  logic                         pool_valid,
  output logic [D_WIDTH*CHANNELS-1:0]  m_data,
  output logic                         m_valid,
  output logic                         m_last,
  input  logic                         m_ready
);

  localparam int DW      = D_WIDTH * CHANNELS;
  localparam int NPIX    = IMAGE_SIZE * IMAGE_SIZE;
  localparam int OUT_DIM = pool_out_dim(IMAGE_SIZE, FILTER_SIZE, STRIDE);
  localparam int NOUT    = OUT_DIM * OUT_DIM;
  localparam int IN_W    = log2_width(NPIX + 1);
  localparam int OUT_W   = log2_width(NOUT + 1);
  localparam int FL_W    = log2_width(FLUSH_MAX + 1);

  localparam logic [IN_W-1:0]  NPIX_C      = IN_W'(NPIX);
  localparam logic [IN_W-1:0]  LAST_PIX_C  = IN_W'(NPIX - 1);
  localparam logic [OUT_W-1:0] NOUT_C      = OUT_W'(NOUT);
  localparam logic [OUT_W-1:0] LAST_OUT_C  = OUT_W'(NOUT - 1);
  localparam logic [FL_W-1:0]  FLUSH_MAX_C = FL_W'(FLUSH_MAX);

  seq_state_t       state, state_next;
  logic [IN_W-1:0]  in_cnt, in_cnt_next;
  logic [OUT_W-1:0] out_cnt, out_cnt_next;
  logic [FL_W-1:0]  flush_cnt, flush_cnt_next;
  logic             frame_err_next;
  logic             done_next;

  logic out_free;
  logic accept;
  logic capture;

  // Handshake and layer-enable paths are purely combinational so a pixel
  // reaches the layer in the cycle it is accepted.
  assign out_free    = !m_valid || m_ready;
  assign s_ready     = (state == STREAM) && out_free;
  assign pool_clk_en = ((state == STREAM) && s_valid && out_free) ||
                       ((state == FLUSH) && out_free);
  assign pool_in     = (state == STREAM) ? s_data : '0;
  assign accept      = s_valid && s_ready;
  assign capture     = pool_clk_en && pool_valid && (out_cnt < NOUT_C);
  assign busy        = (state != IDLE);

  stream_output_reg #(
    .WIDTH(DW)
  ) u_output_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (capture),
    .load_data (pool_data),
    .load_last (out_cnt == LAST_OUT_C),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_cnt    <= '0;
      out_cnt   <= '0;
      flush_cnt <= '0;
      frame_err <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      in_cnt    <= in_cnt_next;
      out_cnt   <= out_cnt_next;
      flush_cnt <= flush_cnt_next;
      frame_err <= frame_err_next;
      done      <= done_next;
    end
  end

  always_comb begin
    // NOTE: every variable driven here gets a default first, so no branch can
    // leave one unassigned and no latch is inferred.
    state_next     = state;
    in_cnt_next    = in_cnt;
    out_cnt_next   = capture ? out_cnt + OUT_W'(1) : out_cnt;
    flush_cnt_next = flush_cnt;
    frame_err_next = frame_err;
    done_next      = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_next     = STREAM;
          in_cnt_next    = '0;
          out_cnt_next   = '0;
          flush_cnt_next = '0;
          frame_err_next = 1'b0;
        end
      end

      STREAM: begin
        if (accept) begin
          in_cnt_next = (in_cnt == NPIX_C) ? in_cnt : in_cnt + IN_W'(1);
          if (in_cnt == LAST_PIX_C) begin
            if (!s_last) frame_err_next = 1'b1;
            // Last window may have been captured with the last pixel itself.
            state_next = (out_cnt_next == NOUT_C) ? DRAIN : FLUSH;
          end else if (s_last) begin
            frame_err_next = 1'b1;
          end
        end
      end

      FLUSH: begin
        if (pool_clk_en && (flush_cnt != FLUSH_MAX_C)) begin
          flush_cnt_next = flush_cnt + FL_W'(1);
        end
        // Decide on post-edge counts so no extra enable is issued after the
        // final capture or the final permitted flush.
        if (out_cnt_next == NOUT_C) begin
          state_next = DRAIN;
        end else if (flush_cnt_next == FLUSH_MAX_C) begin
          frame_err_next = 1'b1;
          state_next     = IDLE;
        end
      end

      DRAIN: begin
        if (m_valid && m_last && m_ready) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pooling_stream_controller.sv
// Randomized frame-level bench: a behavioural pooling layer feeds the
// controller and a window-max scoreboard checks every output beat.
module tb_pooling_stream_controller;

  localparam int N    = 4;
  localparam int F    = 2;
  localparam int S    = 2;
  localparam int FMAX = 4;
  localparam int OD   = (N - F) / S + 1;
  localparam int NOUT = OD * OD;
  localparam int NPIX = N * N;

  logic       clk = 1'b0;
  logic       rst, start, busy, done, frame_err;
  logic [7:0] s_data, pool_in, pool_data, m_data;
  logic       s_valid, s_last, s_ready, pool_clk_en, pool_valid;
  logic       m_valid, m_last, m_ready;

  always #5 clk = ~clk;

  pooling_stream_controller #(
    .D_WIDTH(8), .CHANNELS(1), .IMAGE_SIZE(N), .FILTER_SIZE(F),
    .STRIDE(S), .FLUSH_MAX(FMAX)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .frame_err(frame_err), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready), .pool_clk_en(pool_clk_en),
    .pool_in(pool_in), .pool_data(pool_data), .pool_valid(pool_valid),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- frame data and scoreboard ----------------
  logic [7:0] frame_pix [NPIX];
  logic [7:0] exp_q [$];
  int en_cnt, flush_en, done_cnt, beat_idx;
  bit done_due = 1'b0;

  function automatic logic [7:0] exp_win(input int w);
    logic [7:0] m;
    int wy, wx;
    m  = 8'd0;
    wy = w / OD;
    wx = w % OD;
    for (int dy = 0; dy < F; dy++)
      for (int dx = 0; dx < F; dx++)
        if (frame_pix[(wy * S + dy) * N + wx * S + dx] > m)
          m = frame_pix[(wy * S + dy) * N + wx * S + dx];
    return m;
  endfunction

  // ---------------- behavioural pooling layer ----------------
  // Mode 0 presents a window during the enable of its completing pixel.
  // Mode 1 queues results and releases them in bursts of two, or all
  // remaining ones once the frame has been fed.
  bit         pool_mode = 1'b0;
  bit         pm_withhold = 1'b0;
  int         pl_cnt;
  logic [7:0] pl_buf [NPIX];
  logic [7:0] pq [$];
  bit         burst;
  logic       pc_valid, bq_valid;
  logic [7:0] pc_max, bq_data;
  bit         en_s, rst_s;
  logic [7:0] pin_s;

  assign pool_valid = pool_mode ? bq_valid : pc_valid;
  assign pool_data  = pool_mode ? bq_data : ((pc_max > pool_in) ? pc_max : pool_in);

  function automatic bit completes(input int p);
    int r, c;
    r = p / N;
    c = p % N;
    return (r >= F - 1) && (c >= F - 1) && ((r - F + 1) % S == 0) && ((c - F + 1) % S == 0);
  endfunction

  function automatic int win_of(input int p);
    return ((p / N - F + 1) / S) * OD + (p % N - F + 1) / S;
  endfunction

  function automatic logic [7:0] partial_max(input int p);
    logic [7:0] m;
    int q;
    m = 8'd0;
    for (int dy = 0; dy < F; dy++)
      for (int dx = 0; dx < F; dx++) begin
        q = (p / N - dy) * N + (p % N - dx);
        if (q != p && pl_buf[q] > m) m = pl_buf[q];
      end
    return m;
  endfunction

  task automatic pm_refresh();
    pc_valid = (pl_cnt < NPIX) && completes(pl_cnt) &&
               !(pm_withhold && win_of(pl_cnt) == NOUT - 1);
    pc_max   = pc_valid ? partial_max(pl_cnt) : 8'd0;
    if (pq.size() >= 2 || (pl_cnt >= NPIX && pq.size() > 0)) burst = 1'b1;
    if (pq.size() == 0) burst = 1'b0;
    bq_valid = pool_mode && burst && (pq.size() > 0);
    bq_data  = bq_valid ? pq[0] : 8'd0;
  endtask

  task automatic pm_reset();
    pl_cnt = 0;
    pq.delete();
    burst = 1'b0;
    pm_refresh();
  endtask

  initial begin
    pm_reset();
    forever begin
      @(negedge clk);
      en_s  = pool_clk_en;
      pin_s = pool_in;
      rst_s = rst;
      @(posedge clk);
      #1;
      if (rst_s) begin
        pm_reset();
      end else if (en_s) begin
        if (pool_mode && bq_valid) void'(pq.pop_front());
        if (pl_cnt < NPIX) begin
          pl_buf[pl_cnt] = pin_s;
          if (pool_mode && completes(pl_cnt) && !(pm_withhold && win_of(pl_cnt) == NOUT - 1))
            pq.push_back((partial_max(pl_cnt) > pin_s) ? partial_max(pl_cnt) : pin_s);
          pl_cnt++;
        end
        pm_refresh();
      end
    end
  end

  // ---------------- downstream ready policy ----------------
  int mr_policy = 0;
  int hold_left = 0;
  bit held_once = 1'b0;

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mr_policy)
        1: m_ready = ($urandom_range(99) < 70);
        2: begin
          if (hold_left > 0) begin
            m_ready = 1'b0;
            hold_left--;
          end else if (!held_once && m_valid) begin
            held_once = 1'b1;
            hold_left = 5;
            m_ready   = 1'b0;
          end else begin
            m_ready = 1'b1;
          end
        end
        default: m_ready = 1'b1;
      endcase
    end
  end

  // ---------------- monitor (samples on the falling edge) ----------------
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        done_due = 1'b0;
      end else begin
        if (pool_clk_en) begin
          en_cnt++;
          if (!s_ready) begin
            flush_en++;
            check("flush_pool_in", pool_in, 0);
          end
        end
        if (m_valid && !m_ready) begin
          check("stall_s_ready", s_ready, 0);
          check("stall_clk_en", pool_clk_en, 0);
        end
        if (done || done_due) check("done_pulse", done, done_due);
        if (done) begin
          done_cnt++;
          check("busy_at_done", busy, 0);
        end
        done_due = 1'b0;
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_beat_valid", m_valid, 0);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", m_data, e);
            check("beat_last", m_last, beat_idx == NOUT - 1);
            beat_idx++;
            if (m_last) done_due = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- frame driver ----------------
  task automatic run_frame(input bit pmode, input bit withhold, input int early_last,
                           input bit omit_last, input int rst_at, input int start_at,
                           input int vpct, input int rpolicy, input bit seq);
    int  i, cyc, exp_flush;
    bit  acc, chk_err, chk_cap, err_exp;
    for (int p = 0; p < NPIX; p++) frame_pix[p] = seq ? 8'(p + 1) : 8'($urandom);
    exp_q.delete();
    for (int w = 0; w < NOUT; w++)
      if (!(withhold && w == NOUT - 1)) exp_q.push_back(exp_win(w));
    pool_mode   = pmode;
    pm_withhold = withhold;
    pm_reset();
    mr_policy = rpolicy;
    held_once = 1'b0;
    hold_left = 0;
    en_cnt = 0; flush_en = 0; done_cnt = 0; beat_idx = 0;

    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_err_clear", frame_err, 0);

    i = 0;
    cyc = 0;
    while (i < NPIX && cyc < 400) begin
      s_valid = ($urandom_range(99) < vpct);
      s_data  = frame_pix[i];
      s_last  = (i == early_last) || (i == NPIX - 1 && !omit_last);
      start   = (i == start_at);
      if (i == rst_at) begin
        s_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_m_data", m_data, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_clk_en", pool_clk_en, 0);
        rst = 1'b0; start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        return;
      end
      @(negedge clk);
      acc     = s_valid && s_ready;
      chk_err = acc && (i == early_last) && (early_last != NPIX - 1);
      chk_cap = acc && (i == start_at);
      @(posedge clk);
      #1;
      if (acc) i++;
      cyc++;
      if (chk_err) check("early_last_err", frame_err, 1);
      if (chk_cap) begin
        check("cap_accept_valid", m_valid, 1);
        check("cap_accept_data", m_data, exp_win(1));
      end
    end
    s_valid = 1'b0; s_last = 1'b0; start = 1'b0;
    check("pixels_taken", i, NPIX);

    cyc = 0;
    while ((busy || m_valid) && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("drain_timeout", busy, 0);
    @(posedge clk);
    #1;

    exp_flush = withhold ? FMAX : (pmode ? 2 : 0);
    err_exp   = (early_last >= 0 && early_last != NPIX - 1) || omit_last || withhold;
    check("enables", en_cnt, NPIX + exp_flush);
    check("flush_enables", flush_en, exp_flush);
    check("beats", beat_idx, withhold ? NOUT - 1 : NOUT);
    check("done_count", done_cnt, withhold ? 0 : 1);
    check("frame_err_end", frame_err, err_exp);
    check("idle_end", busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_m_valid", m_valid, 0);
    check("reset_m_last", m_last, 0);
    check("reset_m_data", m_data, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // args: pmode, withhold, early_last, omit_last, rst_at, start_at, vpct, rpolicy, seq
    run_frame(1'b0, 1'b0, -1, 1'b0, -1, -1, 100, 0, 1'b1);  // clean 1..16 frame
    run_frame(1'b0, 1'b0, -1, 1'b0, -1, -1, 100, 2, 1'b1);  // held backpressure
    run_frame(1'b0, 1'b0,  9, 1'b0, -1, -1, 100, 0, 1'b1);  // early s_last
    run_frame(1'b0, 1'b1, -1, 1'b0, -1, -1, 100, 0, 1'b1);  // last window withheld
    run_frame(1'b0, 1'b0, -1, 1'b0,  6, -1, 100, 0, 1'b1);  // reset at pixel 7
    run_frame(1'b0, 1'b0, -1, 1'b0, -1, -1, 100, 0, 1'b1);  // clean frame after reset
    run_frame(1'b1, 1'b0, -1, 1'b0, -1,  9, 100, 0, 1'b1);  // start + capture/accept
    run_frame(1'b0, 1'b0, -1, 1'b1, -1, -1, 100, 0, 1'b0);  // missing s_last
    for (int k = 0; k < 10; k++) begin
      run_frame(1'($urandom_range(1)), ($urandom_range(3) == 0),
                ($urandom_range(3) == 0) ? int'($urandom_range(NPIX - 2)) : -1,
                ($urandom_range(5) == 0), -1, -1, int'($urandom_range(100, 50)), 1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
